// File: rtl/led_fade_sequencer_pkg.sv
// Shared definitions for the LED fade sequencer and the PWM stage:
// the sequencer state encoding and the default widths and timing.
package led_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RISE    = 3'd1,
    HOLD_HI = 3'd2,
    FALL    = 3'd3,
    HOLD_LO = 3'd4
  } led_state_t;

  // Default step of about 10 ms at 25 MHz.
  localparam int LED_STEP_CYCLES = 250000;
  localparam int LED_DUTY_W      = 8;
  localparam int LED_HOLD_W      = 8;
  localparam int LED_CNT_W       = 8;

endpackage

// File: rtl/led_fade_sequencer_step_tick.sv
// Step prescaler: counts 0..STEP_CYCLES-1 while enabled and emits a
// one-cycle tick on the last count. It is held at zero while disabled or cleared.
module led_step_tick #(
  parameter int STEP_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PW-1:0] LAST = PW'(STEP_CYCLES - 1);

  logic [PW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PW'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/led_fade_sequencer.sv
// Breathe-cycle sequencer: steps a registered duty word through rise, hold
// high, fall and hold low, once per step tick, for N cycles or until aborted.
module led_fade_sequencer
  import led_pkg::*;
#(
  parameter int STEP_CYCLES = LED_STEP_CYCLES,
  parameter int DUTY_W      = LED_DUTY_W,
  parameter int HOLD_W      = LED_HOLD_W,
  parameter int CNT_W       = LED_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DUTY_W-1:0] cmd_peak,
  input  logic [HOLD_W-1:0] cmd_hold,
  input  logic [CNT_W-1:0]  cmd_cycles,
  input  logic              abort,
  output logic [DUTY_W-1:0] duty,
  output logic              active,
  output logic              done,
  output logic              aborted,
  output logic [2:0]        state_dbg
);

  led_state_t        state, state_n;
  logic [DUTY_W-1:0] duty_n, peak_q, peak_n;
  logic [HOLD_W-1:0] hold_q, hold_n, hold_cnt, hold_cnt_n;
  logic [CNT_W-1:0]  cycles_q, cycles_n, cycle_cnt, cycle_cnt_n;
  logic              done_n, aborted_n;
  logic              accept, tick;

  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready is high only in IDLE with abort low,
  // so abort always wins over a new command.
  assign cmd_ready = (state == IDLE) && !abort;
  assign accept    = cmd_valid && cmd_ready;
  assign active    = (state != IDLE);
  assign state_dbg = state;

  led_step_tick #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state != IDLE),
    .clr  (accept),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      duty      <= '0;
      peak_q    <= '0;
      hold_q    <= '0;
      cycles_q  <= '0;
      hold_cnt  <= '0;
      cycle_cnt <= '0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      state     <= state_n;
      duty      <= duty_n;
      peak_q    <= peak_n;
      hold_q    <= hold_n;
      cycles_q  <= cycles_n;
      hold_cnt  <= hold_cnt_n;
      cycle_cnt <= cycle_cnt_n;
      done      <= done_n;
      aborted   <= aborted_n;
    end
  end

  always_comb begin
    state_n     = state;
    duty_n      = duty;
    peak_n      = peak_q;
    hold_n      = hold_q;
    cycles_n    = cycles_q;
    hold_cnt_n  = hold_cnt;
    cycle_cnt_n = cycle_cnt;
    done_n      = 1'b0;
    aborted_n   = 1'b0;

    if (abort && (state != IDLE)) begin
      // Abort beats everything, including the final HOLD_LO tick.
      state_n     = IDLE;
      duty_n      = '0;
      hold_cnt_n  = '0;
      cycle_cnt_n = '0;
      aborted_n   = 1'b1;
    end else if (accept) begin
      peak_n      = cmd_peak;
      hold_n      = cmd_hold;
      cycles_n    = cmd_cycles;
      duty_n      = '0;
      hold_cnt_n  = '0;
      cycle_cnt_n = '0;
      state_n     = RISE;
    end else if (tick) begin
      case (state)
        RISE: begin
          if (duty == peak_q) begin
            state_n    = HOLD_HI;
            hold_cnt_n = '0;
          end else begin
            duty_n = duty + DUTY_W'(1);
          end
        end
        HOLD_HI: begin
          if (hold_cnt == hold_q) begin
            state_n = FALL;
          end else begin
            hold_cnt_n = hold_cnt + HOLD_W'(1);
          end
        end
        FALL: begin
          if (duty == '0) begin
            state_n    = HOLD_LO;
            hold_cnt_n = '0;
          end else begin
            duty_n = duty - DUTY_W'(1);
          end
        end
        HOLD_LO: begin
          if (hold_cnt == hold_q) begin
            cycle_cnt_n = cycle_cnt + CNT_W'(1);
            // cycles==0 means run forever; cycle_cnt then just wraps.
            if ((cycles_q != '0) && (cycle_cnt_n == cycles_q)) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              state_n    = RISE;
              hold_cnt_n = '0;
            end
          end else begin
            hold_cnt_n = hold_cnt + HOLD_W'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule
